// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencer with 2-entry fetch buffer, redirect and halt-on-zero.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_CHK_EN.
module fetch_controller #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [PC_WIDTH-1:0] imem_pc,
  input  logic [31:0]         imem_instr,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst_data,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic                halted,
  output logic                misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] r_pc0, r_pc1;
  logic [31:0]         r_data0, r_data1;
  logic [1:0]          r_count;

  logic                w_pop;
  logic                w_attempt;
  logic                w_zero;
  logic                w_space;
  logic                w_push;
  logic [1:0]          w_wr_idx;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_redir_halt;

  assign w_pop     = inst_valid & inst_ready;
  // A fetch is attempted regardless of space, so a zero word halts even when full.
  assign w_attempt = (r_state == S_RUN) & enable & ~redirect_valid;
  assign w_zero    = (imem_instr == 32'h0000_0000);
  assign w_space   = (r_count != 2'd2) | w_pop;
  assign w_push    = w_attempt & ~w_zero & w_space;
  assign w_wr_idx  = r_count - {1'b0, w_pop};

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;
  logic w_mis_now;

  assign w_target     = redirect_pc;
  assign w_mis_now    = (redirect_pc[1:0] != 2'b00);
  assign w_redir_halt = w_mis_now | r_misalign;
  assign misalign_err = r_misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid && w_mis_now) begin
      r_misalign <= 1'b1;
    end
  end
`else
  assign w_target     = redirect_pc & ~PC_WIDTH'(3);
  assign w_redir_halt = 1'b0;
  assign misalign_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_pc0      <= '0;
      r_pc1      <= '0;
      r_data0    <= 32'h0;
      r_data1    <= 32'h0;
    end else if (redirect_valid) begin
      r_count    <= 2'd0;
      r_fetch_pc <= w_target;
      if (w_redir_halt) begin
        r_state <= S_HALT;
      end else if (r_state == S_HALT) begin
        r_state <= S_RUN;
      end
    end else begin
      if (w_pop) begin
        r_data0 <= r_data1;
        r_pc0   <= r_pc1;
      end
      // Push lands after the shift, so it overrides the slot it targets.
      if (w_push) begin
        if (w_wr_idx == 2'd0) begin
          r_data0 <= imem_instr;
          r_pc0   <= r_fetch_pc;
        end else begin
          r_data1 <= imem_instr;
          r_pc1   <= r_fetch_pc;
        end
        r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (r_state == S_IDLE && enable) begin
        r_state <= S_RUN;
      end else if (w_attempt && w_zero) begin
        r_state <= S_HALT;
      end
    end
  end

  assign imem_pc    = r_fetch_pc;
  assign inst_valid = (r_count != 2'd0);
  assign inst_data  = r_data0;
  assign inst_pc    = r_pc0;
  assign halted     = (r_state == S_HALT);

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the processor's instruction memory. It owns the program counter and drives the word address to the combinational instruction memory. Each fetched word is captured with its PC into a 2-entry buffer, which a valid/ready handshake drains toward decode. It also handles redirects (branch/jump targets), the post-reset start gate, and halting on an empty (all-zero) memory word.

## Interface
- PC_WIDTH, 10, width of the PC and of the instruction memory address
- RESET_PC, 0, fetch PC loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = in reset
- enable  in  1  fetch permit; sampled each rising edge
- imem_pc  out  PC_WIDTH  address to instruction memory; equals the fetch PC register
- imem_instr  in  32  instruction word returned combinationally for imem_pc
- redirect_valid  in  1  load redirect_pc as the new fetch PC and flush the buffer
- redirect_pc  in  PC_WIDTH  redirect target
- inst_valid  out  1  buffer head valid
- inst_ready  in  1  consumer accepts the head when inst_valid=1
- inst_data  out  32  head instruction word
- inst_pc  out  PC_WIDTH  PC of the head word
- halted  out  1  state is HALT
- misalign_err  out  1  sticky misaligned-redirect flag; tied 0 unless the macro is defined

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - HALT
- State transitions:
  - IDLE -> RUN when enable=1 at an edge.
  - RUN -> HALT when a capture is attempted and imem_instr==32'h0000_0000. The zero word is not captured and fetch PC does not advance.
  - HALT -> RUN on an accepted redirect.
  - IDLE and HALT never capture.
- Capture: in RUN, a capture occurs at an edge when enable=1, there is no redirect, imem_instr is nonzero, and the buffer has space.
  - Space means count<2, or count==2 with a pop at the same edge.
  - A capture pushes {fetch_pc, imem_instr} and sets fetch_pc <= fetch_pc+4.
- enable=0 in RUN: stall. No capture and no PC change; the buffer still drains.
- Pop: occurs at an edge when inst_valid && inst_ready. The buffer is FIFO ordered; inst_valid = (count!=0).
- Redirect: has priority over capture, pop and halt detection.
  - count <= 0; fetch_pc <= redirect_pc; a pending pop is discarded.
  - In IDLE, a redirect loads the PC but the state stays IDLE.
  - In HALT, a redirect returns the state to RUN.
- PC arithmetic: fetch_pc+4 is modulo 2^PC_WIDTH. 1020 wraps to 0 with no flag.
- Simultaneous push and pop at count==1 or count==2: count is unchanged and ordering is preserved.
- Reset values:
  - state IDLE; fetch_pc/imem_pc = RESET_PC; count 0
  - inst_valid 0; inst_data 0; inst_pc 0
  - halted 0; misalign_err 0
- Reset mid-operation clears everything immediately (asynchronous). Buffered words are lost.

## Timing
- All state is registered on the rising clk edge. The reset assertion acts asynchronously; release is sampled at the edge.
- imem_pc is a register output. The only combinational path is imem_instr -> capture data, which is latched at the same edge.
- Start latency:
  - enable high at edge k: state is RUN after k.
  - First capture at edge k+1; inst_valid=1 after k+1.
- Redirect latency: redirect sampled at edge r; the target word is captured at r+1 and visible on inst_* after r+1.
- Throughput: with inst_ready held at 1, one instruction per cycle.
- inst_ready may depend combinationally on inst_valid. inst_valid must not depend on inst_ready.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 still flushes and loads the PC, sets misalign_err=1 (sticky until reset), and forces state to HALT.
  - Later redirects do not leave HALT while misalign_err=1.
- FETCH_MISALIGN_CHK_EN undefined:
  - redirect_pc[1:0] is forced to 2'b00 on load.
  - misalign_err is constant 0.

## Test plan
- Reset and start:
  - Memory holds nonzero words at 0..12; reset low, then high; enable=1; inst_ready=1.
  - Expect inst_pc = 0,4,8,12 on consecutive cycles, first valid two edges after enable is sampled.
  - All outputs must be 0 (imem_pc = RESET_PC) during reset.
- Backpressure:
  - Hold inst_ready=0 for 5 cycles.
  - Expect count to saturate at 2, imem_pc to stay at 8, and no word lost or duplicated after release.
- Redirect flush:
  - With 2 words buffered, redirect_pc=40 together with inst_ready=1.
  - Expect the pop to be discarded, inst_valid=0 after the edge, and the next word to carry inst_pc=40.
- Halt:
  - Word at 16 = 0.
  - Expect halted=1 after the edge at imem_pc=16, the buffer to drain words 8 and 12, and imem_pc to stay 16.
  - redirect_pc=0 resumes RUN.
- Wrap: redirect_pc=1020 with nonzero words at 1020 and 0; expect inst_pc 1020 then 0.
- Misalign:
  - Macro defined: redirect_pc=6 gives misalign_err=1, halted=1; a following redirect_pc=0 keeps halted=1.
  - Macro undefined: redirect_pc=6 gives imem_pc=4 and misalign_err=0.
